div_iter: RTL

Multi-cycle iterative divider that computes quotient/remainder as the sequential counterpart of the combinational ALU div/rem ops (1110/1111). Operands arrive over a valid/ready request channel; one result is returned over a valid/ready response channel. It sits beside the ALU in the execute stage so that single-cycle combinational division can be removed from the critical path. Flag outputs z/v mirror the ALU's zero/overflow semantics.

---
 rtl/div_iter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative restoring divider: signed/unsigned quotient or remainder over valid/ready channels.
// Optional `DIV_ABORT_EN adds an abort input that discards the operation in flight.
module div_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [1:0]      op,
`ifdef DIV_ABORT_EN
   input  logic            abort,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] r,
   output logic            z,
   output logic            v,
   output logic [1:0]      dbg_state
);

   // Handshakes: a request transfers on a rising edge where in_valid && in_ready;
   // a result transfers on a rising edge where out_valid && out_ready. A side
   // holding valid must keep its payload stable until the transfer.

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [XLEN-1:0] rem_q, rem_n;
   logic [XLEN-1:0] quo_q, quo_n;
   logic [XLEN-1:0] dvs_q, dvs_n;
   logic            sel_rem, sel_rem_n;
   logic            sign_q, sign_q_n;
   logic            sign_r, sign_r_n;
   logic            rdy_q, rdy_n;
   logic [XLEN-1:0] r_q, r_n;
   logic            z_n, v_n;
   logic            abort_w;

`ifdef DIV_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   logic            is_signed;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            b_zero, ovf;
   logic [XLEN-1:0] sp_zero_res, sp_ovf_res;

   assign is_signed   = ~op[1];
   assign a_abs       = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
   assign b_abs       = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
   assign b_zero      = (b == '0);
   assign ovf         = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign sp_zero_res = op[0] ? a : '1;
   assign sp_ovf_res  = op[0] ? '0 : a;

   // The working partial remainder is XLEN+1 bits: shifted remainder plus next dividend bit.
   logic [XLEN:0]   rem_sh, diff;
   logic            qbit;
   logic [XLEN-1:0] rem_st, quo_st, q_fin, r_fin, res_fin;

   assign rem_sh  = {rem_q, quo_q[XLEN-1]};
   assign diff    = rem_sh - {1'b0, dvs_q};
   assign qbit    = ~diff[XLEN];
   assign rem_st  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quo_st  = {quo_q[XLEN-2:0], qbit};
   assign q_fin   = sign_q ? (~quo_st + 1'b1) : quo_st;
   assign r_fin   = sign_r ? (~rem_st + 1'b1) : rem_st;
   assign res_fin = sel_rem ? r_fin : q_fin;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      rem_n     = rem_q;
      quo_n     = quo_q;
      dvs_n     = dvs_q;
      sel_rem_n = sel_rem;
      sign_q_n  = sign_q;
      sign_r_n  = sign_r;
      r_n       = r_q;
      z_n       = z;
      v_n       = v;
      case (state)
         IDLE: begin
            if (in_valid && rdy_q) begin
               sel_rem_n = op[0];
               sign_q_n  = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
               sign_r_n  = is_signed & a[XLEN-1];
               rem_n     = '0;
               quo_n     = a_abs;
               dvs_n     = b_abs;
               cnt_n     = CW'(XLEN-1);
               if (b_zero) begin
                  r_n     = sp_zero_res;
                  z_n     = ~|sp_zero_res;
                  v_n     = 1'b1;
                  state_n = DONE;
               end else if (ovf) begin
                  r_n     = sp_ovf_res;
                  z_n     = ~|sp_ovf_res;
                  v_n     = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = BUSY;
               end
            end
         end
         BUSY: begin
            rem_n = rem_st;
            quo_n = quo_st;
            if (cnt == '0) begin
               r_n     = res_fin;
               z_n     = ~|res_fin;
               v_n     = 1'b0;
               state_n = DONE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (abort_w && state != IDLE) state_n = IDLE;
      rdy_n = (state_n == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sel_rem <= 1'b0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         rdy_q   <= 1'b0;
         r_q     <= '0;
         z       <= 1'b0;
         v       <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         rem_q   <= rem_n;
         quo_q   <= quo_n;
         dvs_q   <= dvs_n;
         sel_rem <= sel_rem_n;
         sign_q  <= sign_q_n;
         sign_r  <= sign_r_n;
         rdy_q   <= rdy_n;
         r_q     <= r_n;
         z       <= z_n;
         v       <= v_n;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state == DONE);
   assign r         = r_q;
   assign dbg_state = state;

endmodule
